// File: rtl/seq_signed_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM encodings and counter sizing.
package seq_signed_divider_pkg;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_PREP = 2'd1;
  localparam logic [1:0] DIV_ITER = 2'd2;
  localparam logic [1:0] DIV_FIX  = 2'd3;

  // Counter must hold the value WIDTH itself, hence w+1.
  function automatic int div_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_signed_divider_step.sv
// One restoring-division iteration on unsigned magnitudes: shift, compare, conditional subtract.
module div_restore_step
  import seq_signed_divider_pkg::*;
#(
  parameter int WIDTH = 69
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] dvd_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] dvd_out,
  output logic             qbit
);

  logic [WIDTH-1:0] shifted_s;

  // rem < dvs <= 2^(WIDTH-1) before the shift, so the shifted value never overflows WIDTH bits.
  always_comb begin
    shifted_s = {rem_in[WIDTH-2:0], dvd_in[WIDTH-1]};
    if (shifted_s >= dvs) begin
      qbit    = 1'b1;
      rem_out = shifted_s - dvs;
    end else begin
      qbit    = 1'b0;
      rem_out = shifted_s;
    end
    dvd_out = {dvd_in[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative radix-2 restoring signed divider; quotient truncates toward zero, remainder takes the dividend's sign.
module seq_signed_divider
  import seq_signed_divider_pkg::*;
#(
  parameter int WIDTH = 69
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             launch,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int               CNT_W    = div_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_dvd_s;
  logic             step_qbit_s;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_in  (dvd_q),
    .dvs     (dvs_q),
    .rem_out (step_rem_s),
    .dvd_out (step_dvd_s),
    .qbit    (step_qbit_s)
  );

  // Next-state and datapath control; dvd_q doubles as the quotient shift register during ITER.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    zero_d    = zero_q;
    quot_d    = quot_q;
    remo_d    = remo_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (launch) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rneg_d = dividend[WIDTH-1];
          if (divisor == '0) begin
            zero_d  = 1'b1;
            state_d = DIV_FIX;
          end else begin
            zero_d  = 1'b0;
            state_d = DIV_PREP;
          end
        end else begin
          state_d = DIV_IDLE;
        end
      end
      DIV_PREP: begin
        // Negating the most-negative value wraps to itself, which is 2^(WIDTH-1) read as unsigned.
        dvd_d     = dvd_q[WIDTH-1] ? -dvd_q : dvd_q;
        dvs_d     = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
        rem_d     = '0;
        counter_d = CNT_LOAD;
        state_d   = DIV_ITER;
      end
      DIV_ITER: begin
        rem_d     = step_rem_s;
        dvd_d     = step_dvd_s | {{(WIDTH-1){1'b0}}, step_qbit_s};
        counter_d = counter_q - CNT_ONE;
        if (counter_q == CNT_ONE) begin
          state_d = DIV_FIX;
        end else begin
          state_d = DIV_ITER;
        end
      end
      DIV_FIX: begin
        if (zero_q) begin
          quot_d = '1;
          remo_d = dvd_q;
        end else begin
          quot_d = qneg_q ? -dvd_q : dvd_q;
          remo_d = rneg_q ? -rem_q : rem_q;
        end
        dbz_d   = zero_q;
        done_d  = 1'b1;
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
    busy_d = (state_d != DIV_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= DIV_IDLE;
      counter_q <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      zero_q    <= 1'b0;
      quot_q    <= '0;
      remo_q    <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      zero_q    <= zero_d;
      quot_q    <= quot_d;
      remo_q    <= remo_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;

endmodule
